// File: rtl/conv_pkg.sv
// Shared types and encodings for the conv_unit control slice.
package conv_pkg;

    typedef enum logic [2:0] {
        ST_CLEAR,
        ST_ISSUE,
        ST_GAP,
        ST_DRAIN,
        ST_CAPTURE,
        ST_SHIFT
    } ctrl_state_t;

    localparam logic [1:0] ASEL_HOLD  = 2'd0;
    localparam logic [1:0] ASEL_SHIFT = 2'd1;
    localparam logic [1:0] ASEL_ZERO  = 2'd2;

    localparam logic TSEL_CHAIN   = 1'b0;
    localparam logic TSEL_CAPTURE = 1'b1;

endpackage

// File: rtl/conv_unit_ctrl_lat_counter.sv
// Loadable down-counter; done while the count sits at zero.
module lat_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         load,
    input  logic [W-1:0] load_val,
    input  logic         dec,
    output logic         done
);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (rst) begin
            cnt <= '0;
        end else if (load) begin
            cnt <= load_val;
        end else if (dec && cnt != '0) begin
            cnt <= cnt - 1'b1;
        end
    end

    assign done = (cnt == '0);

endmodule

// File: rtl/conv_unit_ctrl.sv
// Issue/flush/capture/shift sequencer for one conv_unit row.
module conv_unit_ctrl
    import conv_pkg::*;
#(
    parameter int DATA_WIDTH = 16,
    parameter int MUL_LAT    = 6,
    parameter int ADD_LAT    = 11,
    parameter int SHIFT_LEN  = 3
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] s_data,
    input  logic                  s_valid,
    input  logic                  s_last,
    output logic                  s_ready,
    input  logic                  m_ready,
    output logic                  m_valid,
    output logic [DATA_WIDTH-1:0] d_out,
    output logic                  dv_in,
    output logic                  MA_en,
    output logic [1:0]            A_sel,
    output logic                  T_en,
    output logic                  T_sel,
    output logic                  busy
);

    localparam int FLUSH = MUL_LAT + ADD_LAT;
    localparam int CMAX  = (FLUSH > SHIFT_LEN) ? FLUSH : SHIFT_LEN;
    localparam int CW    = $clog2(CMAX + 1);

    localparam logic [CW-1:0] LD_BOOT  = CW'(FLUSH - 2);
    localparam logic [CW-1:0] LD_FLUSH = CW'(FLUSH - 1);
    localparam logic [CW-1:0] LD_GAP   = CW'(ADD_LAT - 1);
    localparam logic [CW-1:0] LD_SHIFT = CW'(SHIFT_LEN - 1);

    ctrl_state_t   state;
    logic          boot;
    logic          t_cap;
    logic          hs;
    logic          beat;
    logic          cnt_load;
    logic          cnt_dec;
    logic [CW-1:0] cnt_val;
    logic          cnt_done;

    assign hs   = s_valid & s_ready;
    assign beat = m_valid & m_ready;
    assign T_en = t_cap | beat;

    // After reset the counter holds zero, so the first CLEAR cycle loads it.
    always_comb begin
        cnt_load = 1'b0;
        cnt_dec  = 1'b0;
        cnt_val  = '0;
        unique case (state)
            ST_CLEAR: begin
                cnt_load = boot;
                cnt_val  = LD_BOOT;
                cnt_dec  = ~boot;
            end
            ST_ISSUE: begin
                cnt_load = hs;
                cnt_val  = s_last ? LD_FLUSH : LD_GAP;
            end
            ST_GAP, ST_DRAIN: cnt_dec = 1'b1;
            ST_CAPTURE: begin
                cnt_load = 1'b1;
                cnt_val  = LD_SHIFT;
            end
            ST_SHIFT: begin
                cnt_load = beat & cnt_done;
                cnt_val  = LD_FLUSH;
                cnt_dec  = beat;
            end
            default: ;
        endcase
    end

    lat_counter #(
        .W(CW)
    ) u_cnt (
        .clk      (clk),
        .rst      (rst),
        .load     (cnt_load),
        .load_val (cnt_val),
        .dec      (cnt_dec),
        .done     (cnt_done)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state   <= ST_CLEAR;
            boot    <= 1'b1;
            d_out   <= '0;
            dv_in   <= 1'b0;
            s_ready <= 1'b0;
            m_valid <= 1'b0;
            t_cap   <= 1'b0;
            T_sel   <= TSEL_CHAIN;
            A_sel   <= ASEL_ZERO;
            MA_en   <= 1'b1;
            busy    <= 1'b1;
        end else begin
            dv_in <= 1'b0;
            t_cap <= 1'b0;
            unique case (state)
                ST_CLEAR: begin
                    boot <= 1'b0;
                    if (cnt_done && !boot) begin
                        state   <= ST_ISSUE;
                        s_ready <= 1'b1;
                        A_sel   <= ASEL_SHIFT;
                        busy    <= 1'b0;
                    end
                end
                ST_ISSUE: begin
                    if (hs) begin
                        d_out   <= s_data;
                        dv_in   <= 1'b1;
                        s_ready <= 1'b0;
                        busy    <= 1'b1;
                        state   <= s_last ? ST_DRAIN : ST_GAP;
                    end
                end
                ST_GAP: begin
                    if (cnt_done) begin
                        state   <= ST_ISSUE;
                        s_ready <= 1'b1;
                        busy    <= 1'b0;
                    end
                end
                ST_DRAIN: begin
                    if (cnt_done) begin
                        state <= ST_CAPTURE;
                        MA_en <= 1'b0;
                        A_sel <= ASEL_HOLD;
                        t_cap <= 1'b1;
                        T_sel <= TSEL_CAPTURE;
                    end
                end
                ST_CAPTURE: begin
                    state   <= ST_SHIFT;
                    T_sel   <= TSEL_CHAIN;
                    m_valid <= 1'b1;
                end
                ST_SHIFT: begin
                    if (beat && cnt_done) begin
                        state   <= ST_CLEAR;
                        m_valid <= 1'b0;
                        MA_en   <= 1'b1;
                        A_sel   <= ASEL_ZERO;
                    end
                end
                default: state <= ST_CLEAR;
            endcase
        end
    end

endmodule

// File: tb/tb_conv_unit_ctrl.sv
// Directed bench for conv_unit_ctrl with MUL_LAT=2, ADD_LAT=3, SHIFT_LEN=3.
module tb_conv_unit_ctrl;
    import conv_pkg::*;

    logic        clk = 1'b0;
    logic        rst;
    logic [15:0] s_data;
    logic        s_valid;
    logic        s_last;
    logic        s_ready;
    logic        m_ready;
    logic        m_valid;
    logic [15:0] d_out;
    logic        dv_in;
    logic        MA_en;
    logic [1:0]  A_sel;
    logic        T_en;
    logic        T_sel;
    logic        busy;

    int errors = 0;
    int checks = 0;

    logic [15:0] pix [0:4];

    conv_unit_ctrl #(
        .DATA_WIDTH (16),
        .MUL_LAT    (2),
        .ADD_LAT    (3),
        .SHIFT_LEN  (3)
    ) dut (
        .clk     (clk),
        .rst     (rst),
        .s_data  (s_data),
        .s_valid (s_valid),
        .s_last  (s_last),
        .s_ready (s_ready),
        .m_ready (m_ready),
        .m_valid (m_valid),
        .d_out   (d_out),
        .dv_in   (dv_in),
        .MA_en   (MA_en),
        .A_sel   (A_sel),
        .T_en    (T_en),
        .T_sel   (T_sel),
        .busy    (busy)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got,
                       input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     tag, got, exp, $time);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Leaves the bench on the first ISSUE cycle after reset.
    task automatic do_reset(input int n);
        rst     = 1'b1;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;
        repeat (n) step();
        chk("rst_dv", dv_in, 0);
        chk("rst_srdy", s_ready, 0);
        chk("rst_mvld", m_valid, 0);
        chk("rst_ten", T_en, 0);
        chk("rst_tsel", T_sel, 0);
        chk("rst_asel", A_sel, 2);
        chk("rst_maen", MA_en, 1);
        chk("rst_busy", busy, 1);
        chk("rst_dout", d_out, 0);
        rst     = 1'b0;
        m_ready = 1'b1;
        #1;
        chk("rst_ten_mr", T_en, 0);
        m_ready = 1'b0;
        for (int i = 0; i < 5; i++) begin
            chk("clr_asel", A_sel, 2);
            chk("clr_maen", MA_en, 1);
            chk("clr_srdy", s_ready, 0);
            chk("clr_dv", dv_in, 0);
            chk("clr_mvld", m_valid, 0);
            step();
        end
        chk("issue_srdy", s_ready, 1);
        chk("issue_busy", busy, 0);
    endtask

    // Entered on an ISSUE cycle; returns on the next ISSUE cycle.
    task automatic run_row(input int first, input int n,
                           input logic [4:0] pat, input int plen);
        int last_c;
        int k;
        int beats;
        bit exp_dv;
        last_c = 4 * (n - 1);
        beats  = 0;
        for (int c = 0; c <= last_c + 5; c++) begin
            k = c / 4;
            exp_dv = (c >= 1) && ((c - 1) % 4 == 0) && (c <= last_c + 1);
            chk("srdy", s_ready, ((c % 4 == 0) && (c <= last_c)) ? 1 : 0);
            chk("dv_in", dv_in, exp_dv ? 1 : 0);
            if (exp_dv)
                chk("d_out", d_out, pix[first + (c - 1) / 4]);
            chk("asel", A_sel, 1);
            chk("maen", MA_en, 1);
            chk("mvld", m_valid, 0);
            s_valid = (c <= last_c);
            s_data  = pix[first + ((k < n) ? k : n - 1)];
            s_last  = (k == n - 1);
            step();
        end
        s_valid = 1'b0;
        s_last  = 1'b0;
        chk("cap_ten", T_en, 1);
        chk("cap_tsel", T_sel, 1);
        chk("cap_maen", MA_en, 0);
        chk("cap_mvld", m_valid, 0);
        step();
        for (int i = 0; i < plen; i++) begin
            chk("sh_mvld", m_valid, 1);
            chk("sh_tsel", T_sel, 0);
            chk("sh_maen", MA_en, 0);
            m_ready = pat[i];
            #1;
            chk("sh_ten", T_en, {31'd0, pat[i]});
            if (m_valid && m_ready)
                beats++;
            step();
        end
        m_ready = 1'b0;
        chk("beats", beats, 3);
        chk("end_mvld", m_valid, 0);
        chk("end_asel", A_sel, 2);
        chk("end_ten", T_en, 0);
        for (int i = 0; i < 5; i++) begin
            chk("clr2_srdy", s_ready, 0);
            chk("clr2_dv", dv_in, 0);
            step();
        end
    endtask

    initial begin
        pix[0] = 16'h3C00;
        pix[1] = 16'h3E00;
        pix[2] = 16'h4000;
        pix[3] = 16'h4400;
        pix[4] = 16'h4500;
        rst     = 1'b1;
        s_data  = '0;
        s_valid = 1'b0;
        s_last  = 1'b0;
        m_ready = 1'b0;

        do_reset(2);
        run_row(0, 4, 5'b11001, 5);
        run_row(4, 1, 5'b00111, 3);

        // reset while in GAP
        chk("g_srdy", s_ready, 1);
        s_valid = 1'b1;
        s_data  = 16'h4600;
        s_last  = 1'b0;
        step();
        s_valid = 1'b0;
        chk("g_dv", dv_in, 1);
        chk("g_dout", d_out, 16'h4600);
        step();
        chk("g_dv2", dv_in, 0);
        do_reset(1);

        // reset while in SHIFT
        s_valid = 1'b1;
        s_data  = 16'h4700;
        s_last  = 1'b1;
        step();
        s_valid = 1'b0;
        s_last  = 1'b0;
        repeat (6) step();
        chk("s_mvld", m_valid, 1);
        chk("s_ten", T_en, 0);
        do_reset(1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
